// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: instruction-sequencing controller for the miniRISC core.
//
// Owns the PC and fetches each instruction through a req/ack handshake on the
// instruction memory. It issues the instruction to the backend, waits for the
// branch resolution, and then computes the next PC.
//
// Ports
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   imem_req/addr/ack/rdata instruction fetch handshake (addr = pc)
//   instr_valid/instr/...   issued instruction and its PC; held while stall=1
//   stall                   backend not ready, holds issue
//   br_valid, br_type, ...  branch resolution for the issued instruction
//   flag_z, flag_n          condition flags used by conditional branches
//   halt                    enter HALT after the current resolution
//   link_we, link_data      BL link write (instr_pc + 4), 1-cycle pulse
//   halted                  controller parked in HALT until reset
//   taken_cnt               saturating taken-branch counter (BRANCH_STATS_EN only)
//
// Optional feature macro: BRANCH_STATS_EN
module branch_pc_ctrl #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic             instr_valid,
   output logic [31:0]      instr,
   output logic [31:0]      instr_pc,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [2:0]       br_type,
   input  logic [25:0]      br_label,
   input  logic [15:0]      br_off,
   input  logic [31:0]      br_reg,
   input  logic             flag_z,
   input  logic             flag_n,
   input  logic             halt,
   output logic             link_we,
   output logic [31:0]      link_data,
   output logic             halted
`ifdef BRANCH_STATS_EN
  ,output logic [CNT_W-1:0] taken_cnt
`endif
);

   typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_RESOLVE, S_HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] seq, ext26s, ext16s;
   logic        fetch_done, resolve, cond_taken, br_taken;

   // Ack only counts while a request is actually outstanding. This keeps a
   // late ack after reset (req already dropped) from being taken.
   assign fetch_done = (state == S_FETCH) && imem_req && imem_ack;
   assign resolve    = (state == S_RESOLVE) && br_valid;

   always_comb begin
      seq        = instr_pc + 32'd4;
      // Sign-extended fields, already scaled by 4 (word offsets).
      ext26s     = {{4{br_label[25]}}, br_label, 2'b00};
      ext16s     = {{14{br_off[15]}}, br_off, 2'b00};
      cond_taken = 1'b0;
      case (br_type)
         3'd4:    cond_taken = flag_z;
         3'd5:    cond_taken = !flag_z;
         3'd6:    cond_taken = flag_n;
         3'd7:    cond_taken = !flag_n;
         default: cond_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      br_taken  = 1'b0;
      case (state)
         S_FETCH: begin
            if (fetch_done) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (!stall) state_nxt = S_RESOLVE;
         end
         S_RESOLVE: begin
            if (br_valid) begin
               case (br_type)
                  3'd1, 3'd2: begin
                     pc_nxt   = seq + ext26s;
                     br_taken = 1'b1;
                  end
                  3'd3: begin
                     // Register target is word-aligned by clearing the low bits.
                     pc_nxt   = br_reg & ~32'd3;
                     br_taken = 1'b1;
                  end
                  3'd4, 3'd5, 3'd6, 3'd7: begin
                     pc_nxt   = cond_taken ? seq + ext16s : seq;
                     br_taken = cond_taken;
                  end
                  default: pc_nxt = seq;
               endcase
               state_nxt = halt ? S_HALT : S_FETCH;
            end
         end
         default: state_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         pc       <= PC_RESET;
         imem_req <= 1'b0;
         instr    <= '0;
         instr_pc <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         // Registered request: low for the first cycle after reset, dropped on
         // the ack edge, and raised on the edge that re-enters FETCH.
         imem_req <= (state_nxt == S_FETCH);
         if (fetch_done) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
         end
      end
   end

   assign imem_addr   = pc;
   assign instr_valid = (state == S_ISSUE);
   assign halted      = (state == S_HALT);
   assign link_we     = resolve && (br_type == 3'd2);
   assign link_data   = link_we ? seq : '0;

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         taken_cnt <= '0;
      else if (resolve && br_taken && (taken_cnt != {CNT_W{1'b1}}))
         taken_cnt <= taken_cnt + 1'b1;
   end
`else
   logic unused_taken;
   assign unused_taken = br_taken;
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Bench for branch_pc_ctrl. Drives a table of instructions through
// fetch/issue/resolve and checks the results through the pc/instr scoreboards.
// It also runs a few hand-written sequences: a reset mid-handshake and a halt.
module tb_branch_pc_ctrl;

   localparam logic [31:0] PC_RST = 32'h0000_0000;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr, instr_pc;
   logic        stall = 1'b0, br_valid = 1'b0;
   logic [2:0]  br_type = '0;
   logic [25:0] br_label = '0;
   logic [15:0] br_off = '0;
   logic [31:0] br_reg = '0;
   logic        flag_z = 1'b0, flag_n = 1'b0, halt = 1'b0;
   logic        link_we, halted;
   logic [31:0] link_data;
`ifdef BRANCH_STATS_EN
   logic [1:0]  taken_cnt;
`endif

   branch_pc_ctrl #(.PC_RESET(PC_RST), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .stall(stall), .br_valid(br_valid), .br_type(br_type),
      .br_label(br_label), .br_off(br_off), .br_reg(br_reg), .flag_z(flag_z),
      .flag_n(flag_n), .halt(halt), .link_we(link_we), .link_data(link_data),
      .halted(halted)
`ifdef BRANCH_STATS_EN
     ,.taken_cnt(taken_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          stl;
      int          wt;
      logic [2:0]  typ;
      logic [25:0] lbl;
      logic [15:0] off;
      logic [31:0] rg;
      logic        z, n, hlt;
      logic [31:0] ipc, nxt;
      logic        lnk;
   } vec_t;

   vec_t        tv[17];
   logic [31:0] sb_pc[$];
   logic [31:0] sb_ins[$];
   int          nchk = 0, nerr = 0;

   function automatic vec_t mk(logic [31:0] data, int stl, int wt, logic [2:0] typ,
                               logic [25:0] lbl, logic [15:0] off, logic [31:0] rg,
                               logic z, logic n, logic hlt, logic [31:0] ipc,
                               logic [31:0] nxt, logic lnk);
      vec_t v;
      v.data = data; v.stl = stl; v.wt = wt; v.typ = typ; v.lbl = lbl; v.off = off;
      v.rg = rg; v.z = z; v.n = n; v.hlt = hlt; v.ipc = ipc; v.nxt = nxt; v.lnk = lnk;
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_req;
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_wait", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic run_instr(input vec_t v, input int idx);
      logic [31:0] e;
      wait_req();
      e = sb_pc.pop_front();
      chk($sformatf("fetch_addr[%0d]", idx), imem_addr, e);
      imem_ack = 1'b1; imem_rdata = v.data;
      sb_ins.push_back(v.data);
      tick();
      imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
      e = sb_ins.pop_front();
      chk($sformatf("issue_valid[%0d]", idx), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("issue_instr[%0d]", idx), instr, e);
      chk($sformatf("issue_pc[%0d]", idx), instr_pc, v.ipc);
      for (int s = 0; s < v.stl; s++) begin
         stall = 1'b1;
         // Spurious resolution and ack while stalled in ISSUE must be ignored.
         br_valid = (s == 0); br_type = 3'd3; br_reg = 32'h5550;
         imem_ack = (s == 0); imem_rdata = 32'hDEAD_BEEF;
         tick();
         br_valid = 1'b0; imem_ack = 1'b0;
         if (instr_valid !== 1'b1 || instr !== e || instr_pc !== v.ipc)
            chk($sformatf("stall_hold[%0d.%0d]", idx, s), instr, ~e);
         else
            chk($sformatf("stall_hold[%0d.%0d]", idx, s), instr, e);
      end
      stall = 1'b0;
      tick();
      chk($sformatf("accept_drop[%0d]", idx), {31'd0, instr_valid}, 32'd0);
      for (int w = 0; w < v.wt; w++) tick();
      br_valid = 1'b1; br_type = v.typ; br_label = v.lbl; br_off = v.off;
      br_reg = v.rg; flag_z = v.z; flag_n = v.n; halt = v.hlt;
      #1;
      chk($sformatf("link_we[%0d]", idx), {31'd0, link_we}, {31'd0, v.lnk});
      if (v.lnk) chk($sformatf("link_data[%0d]", idx), link_data, v.ipc + 32'd4);
      if (!v.hlt) sb_pc.push_back(v.nxt);
      tick();
      br_valid = 1'b0; halt = 1'b0; flag_z = 1'b0; flag_n = 1'b0;
      chk($sformatf("link_drop[%0d]", idx), {31'd0, link_we}, 32'd0);
   endtask

   task automatic mid_reset;
      logic [31:0] e;
      wait_req();
      e = sb_pc.pop_front();
      chk("prereset_addr", imem_addr, e);
`ifdef BRANCH_STATS_EN
      chk("taken_cnt_sat", {30'd0, taken_cnt}, 32'd3);
`endif
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      chk("midrst_addr", imem_addr, PC_RST);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_0001;
      tick();
      imem_ack = 1'b0;
      chk("late_ack_ignored", {31'd0, instr_valid}, 32'd0);
      chk("late_ack_instr", instr, 32'd0);
`ifdef BRANCH_STATS_EN
      chk("taken_cnt_rst", {30'd0, taken_cnt}, 32'd0);
`endif
      sb_pc.push_back(PC_RST);
   endtask

   initial begin
      tv[0]  = mk(32'h1234, 0, 0, 3'd3, '0, '0, 32'h100, 0, 0, 0, 32'h0,   32'h100, 0);
      tv[1]  = mk(32'hA001, 0, 0, 3'd1, 26'h3FFFFFE, '0, '0, 0, 0, 0, 32'h100, 32'hFC, 0);
      tv[2]  = mk(32'hA002, 0, 1, 3'd0, '0, '0, '0, 0, 0, 0, 32'hFC,  32'h100, 0);
      tv[3]  = mk(32'hA003, 0, 0, 3'd2, 26'h3FFFFFE, '0, '0, 0, 0, 0, 32'h100, 32'hFC, 1);
      tv[4]  = mk(32'hA004, 5, 0, 3'd0, '0, '0, '0, 0, 0, 0, 32'hFC,  32'h100, 0);
      tv[5]  = mk(32'hA005, 0, 0, 3'd4, '0, 16'h0010, '0, 1, 0, 0, 32'h100, 32'h144, 0);
      tv[6]  = mk(32'hA006, 1, 2, 3'd3, '0, '0, 32'h103, 0, 0, 0, 32'h144, 32'h100, 0);
      tv[7]  = mk(32'hA007, 0, 0, 3'd4, '0, 16'h0010, '0, 0, 0, 0, 32'h100, 32'h104, 0);
      tv[8]  = mk(32'hA008, 0, 0, 3'd5, '0, 16'hFFFF, '0, 0, 0, 0, 32'h104, 32'h104, 0);
      tv[9]  = mk(32'hA009, 0, 0, 3'd6, '0, 16'hFFFE, '0, 0, 1, 0, 32'h104, 32'h100, 0);
      tv[10] = mk(32'hA00A, 0, 0, 3'd7, '0, 16'h0010, '0, 0, 1, 0, 32'h100, 32'h104, 0);
      tv[11] = mk(32'hA00B, 0, 0, 3'd7, '0, 16'h0010, '0, 0, 0, 0, 32'h104, 32'h148, 0);
      tv[12] = mk(32'hA00C, 0, 0, 3'd5, '0, 16'h0010, '0, 1, 0, 0, 32'h148, 32'h14C, 0);
      tv[13] = mk(32'hA00D, 0, 0, 3'd6, '0, 16'h0010, '0, 0, 0, 0, 32'h14C, 32'h150, 0);
      tv[14] = mk(32'hA00E, 0, 0, 3'd3, '0, '0, 32'hFFFF_FFFC, 0, 0, 0, 32'h150, 32'hFFFF_FFFC, 0);
      tv[15] = mk(32'hA00F, 0, 0, 3'd0, '0, '0, '0, 0, 0, 0, 32'h0, 32'h4, 0);
      tv[16] = mk(32'hA010, 0, 0, 3'd1, '0, '0, '0, 0, 0, 1, 32'h4, 32'h0, 0);

      tick(); tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, PC_RST);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_ipc", instr_pc, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_link", {31'd0, link_we}, 32'd0);
`ifdef BRANCH_STATS_EN
      chk("rst_cnt", {30'd0, taken_cnt}, 32'd0);
`endif
      rst_n = 1'b1;
      sb_pc.push_back(PC_RST);

      for (int i = 0; i < 17; i++) begin
         if (i == 15) mid_reset();
         run_instr(tv[i], i);
      end

      chk("halted", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      begin
         logic seen = 1'b0;
         for (int c = 0; c < 6; c++) begin
            imem_ack = 1'b1; br_valid = 1'b1;
            tick();
            seen |= imem_req | ~halted | instr_valid;
         end
         imem_ack = 1'b0; br_valid = 1'b0;
         chk("halt_sticky", {31'd0, seen}, 32'd0);
      end
`ifdef BRANCH_STATS_EN
      chk("taken_cnt_end", {30'd0, taken_cnt}, 32'd1);
`endif
      chk("sb_pc_empty", sb_pc.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
